micro_sequencer: RTL
====================

Name: micro_sequencer

Overview:
- Control-section sequencer for the ARC-style microprogrammed datapath.
- Holds the control store address register (CSAI) and the microinstruction register (MIR).
- Drives the address of the combinational microcode ROM (11-bit address, 41-bit word) and latches the returned word.
- Computes the next microaddress from the MIR COND/JUMP fields, the PSR flags and the instruction register, and stalls on main-memory read/write handshakes.

Parameters:
AW, 11, control store address width
UW, 41, microword width

Ports:
CLOCK_50  in  1  system clock; all state changes on its rising edge
RESET_InLow  in  1  asynchronous, active-low reset
ROM_ADDR  out  AW  control store address (= CSAI)
ROM_DATA  in  UW  microword from ROM, combinational from ROM_ADDR
MIR  out  UW  current microinstruction, held to the datapath
DP_COMMIT  out  1  one-cycle strobe: datapath writes the register file and PSR this cycle
FLAG_N, FLAG_Z, FLAG_V, FLAG_C  in  1 each  PSR flags as registered by the datapath
IR_OP  in  2  IR[31:30]
IR_OP3  in  6  IR[24:19]
IR_B13  in  1  IR[13]
MEM_REQ  out  1  memory access request; held high while waiting
MEM_ACK  in  1  memory done; single-cycle pulse or level

Behaviour:
- Reset is asynchronous and active-low on RESET_InLow; the block uses one clock, CLOCK_50.
- Reset values: CSAI=0, MIR=0, state=LOAD, MEM_REQ=0, DP_COMMIT=0.
- MIR field layout, MSB first:
  - A[40:35], AMUX[34], B[33:28], BMUX[27], C[26:21], CMUX[20]
  - RD[19], WR[18], ALU[17:14], COND[13:11], JUMP[10:0]
- FSM states: LOAD, EXEC, WAIT.
- LOAD:
  - MIR <= ROM_DATA.
  - Go to EXEC.
  - DP_COMMIT=0, MEM_REQ=0.
- EXEC, MIR RD=0 and WR=0:
  - DP_COMMIT=1 this cycle.
  - CSAI <= next.
  - Go to LOAD.
- EXEC, RD or WR set:
  - MEM_REQ=1 (combinational from state and MIR).
  - Go to WAIT; CSAI unchanged.
  - If MEM_ACK is already high in EXEC, treat as WAIT-with-ack: commit, CSAI <= next, go to LOAD.
- WAIT:
  - MEM_REQ=1.
  - On MEM_ACK=1: DP_COMMIT=1, CSAI <= next, go to LOAD.
  - Otherwise stay in WAIT indefinitely. There is no timeout.
- Throughput: 2 cycles per microinstruction without memory access; 2 + wait cycles with memory access.
- Flags and IR are sampled in the commit cycle. The flags seen are those committed by the previous microinstruction.
- Next-address selection by COND:
  - 000: CSAI+1
  - 001: N ? JUMP : CSAI+1
  - 010: Z ? JUMP : CSAI+1
  - 011: V ? JUMP : CSAI+1
  - 100: C ? JUMP : CSAI+1
  - 101: IR_B13 ? JUMP : CSAI+1
  - 110: JUMP
  - 111: decode = {1'b1, IR_OP, IR_OP3, 2'b00}
- Arithmetic: CSAI+1 is modulo 2^AW, so 2047+1 wraps to 0.
- Example decode: IR_OP=2'b10, IR_OP3=6'b010000 gives 1600.
- Reset asserted mid-WAIT: MEM_REQ drops immediately (asynchronously); no commit occurs. A late MEM_ACK arriving in LOAD is ignored.
- MEM_ACK is ignored in LOAD, and in EXEC when RD=WR=0.
- RD and WR both set: treated as a single access; MEM_REQ is asserted once.

Decomposition:
- Shared package micro_pkg:
  - MIR field bit positions
  - COND encodings (COND_NEXT, COND_N, COND_Z, COND_V, COND_C, COND_IR13, COND_JUMP, COND_DECODE)
  - FSM state encodings
  - AW/UW defaults
- One combinational sub-module, micro_next_addr (the control branch logic):
  - Inputs: CSAI, COND, JUMP, flags, IR fields.
  - Output: next address.
- All state stays in micro_sequencer.

Test Plan:
- Reset: hold RESET_InLow=0, ROM returns word W0 at address 0; release. Then:
  - ROM_ADDR=0 and MIR=0 during reset.
  - After one clock MIR=W0.
  - DP_COMMIT pulses in the second cycle.
- Decode: MIR COND=111, IR_OP=10, IR_OP3=010000 -> after commit ROM_ADDR=1600. With IR_OP3=010110 -> 1624.
- Conditional jump: at CSAI=1600, COND=101, JUMP=1602.
  - IR_B13=1 -> ROM_ADDR=1602.
  - IR_B13=0 -> ROM_ADDR=1601.
  - Repeat with COND=010 and Z=0/1 at CSAI=1088.
- Memory stall: microword with RD=1, MEM_ACK asserted 3 cycles after entering WAIT ->
  - MEM_REQ high 4 cycles.
  - Exactly one DP_COMMIT, coincident with MEM_ACK.
  - CSAI advances once.
- Wrap: CSAI=2047, COND=000 -> ROM_ADDR=0 after commit. CSAI=2047, COND=110, JUMP=0 -> 0.
- Reset mid-WAIT: assert RESET_InLow=0 in WAIT ->
  - MEM_REQ=0 the same cycle, CSAI=0, no DP_COMMIT.
  - A subsequent MEM_ACK pulse in LOAD has no effect.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the microprogrammed control section: microword field
// positions, branch condition codes and sequencer states.
package micro_pkg;

    localparam int AW_DEF = 11;
    localparam int UW_DEF = 41;

    localparam int F_A_LSB    = 35;
    localparam int F_AMUX     = 34;
    localparam int F_B_LSB    = 28;
    localparam int F_BMUX     = 27;
    localparam int F_C_LSB    = 21;
    localparam int F_CMUX     = 20;
    localparam int F_RD       = 19;
    localparam int F_WR       = 18;
    localparam int F_ALU_LSB  = 14;
    localparam int F_COND_LSB = 11;
    localparam int F_JUMP_LSB = 0;
    localparam int COND_W     = 3;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/micro_next_addr.sv
// Control branch logic: picks the next control store address from the
// microword COND/JUMP fields, the PSR flags and the instruction register.
module micro_next_addr
    import micro_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0]     csai,
    input  logic [COND_W-1:0] cond,
    input  logic [AW-1:0]     jump,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic              flag_v,
    input  logic              flag_c,
    input  logic [1:0]        ir_op,
    input  logic [5:0]        ir_op3,
    input  logic              ir_b13,
    output logic [AW-1:0]     next_addr
);

    logic [AW-1:0] seq_addr;

    // Sequential successor wraps naturally at the top of the control store.
    assign seq_addr = csai + AW'(1);

    always_comb begin
        next_addr = seq_addr;
        case (cond_e'(cond))
            COND_N:      if (flag_n) next_addr = jump;
            COND_Z:      if (flag_z) next_addr = jump;
            COND_V:      if (flag_v) next_addr = jump;
            COND_C:      if (flag_c) next_addr = jump;
            COND_IR13:   if (ir_b13) next_addr = jump;
            COND_JUMP:   next_addr = jump;
            COND_DECODE: next_addr = AW'({1'b1, ir_op, ir_op3, 2'b00});
            default:     next_addr = seq_addr;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns CSAI and MIR, fetches from the microcode ROM and
// stalls on main-memory handshakes before committing each microinstruction.
//
// state   | meaning
// LOAD    | latch ROM word at CSAI into MIR
// EXEC    | execute MIR; commit now unless a memory access must wait
// WAIT    | memory request outstanding; commit on MEM_ACK
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int UW = UW_DEF
) (
    input  logic          CLOCK_50,
    input  logic          RESET_InLow,
    output logic [AW-1:0] ROM_ADDR,
    input  logic [UW-1:0] ROM_DATA,
    output logic [UW-1:0] MIR,
    output logic          DP_COMMIT,
    input  logic          FLAG_N,
    input  logic          FLAG_Z,
    input  logic          FLAG_V,
    input  logic          FLAG_C,
    input  logic [1:0]    IR_OP,
    input  logic [5:0]    IR_OP3,
    input  logic          IR_B13,
    output logic          MEM_REQ,
    input  logic          MEM_ACK
);

    state_e        state_q, state_d;
    logic [AW-1:0] csai_q;
    logic [UW-1:0] mir_q;
    logic [AW-1:0] next_addr;
    logic          mem_access;
    logic          commit;
    logic          mem_req;

    // RD and WR together still form a single access.
    assign mem_access = mir_q[F_RD] | mir_q[F_WR];

    micro_next_addr #(.AW(AW)) u_next_addr (
        .csai      (csai_q),
        .cond      (mir_q[F_COND_LSB +: COND_W]),
        .jump      (mir_q[F_JUMP_LSB +: AW]),
        .flag_n    (FLAG_N),
        .flag_z    (FLAG_Z),
        .flag_v    (FLAG_V),
        .flag_c    (FLAG_C),
        .ir_op     (IR_OP),
        .ir_op3    (IR_OP3),
        .ir_b13    (IR_B13),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        mem_req = 1'b0;
        case (state_q)
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: begin
                if (!mem_access) begin
                    commit  = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    mem_req = 1'b1;
                    if (MEM_ACK) begin
                        commit  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (MEM_ACK) begin
                    commit  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state_q <= ST_LOAD;
            csai_q  <= '0;
            mir_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOAD) mir_q <= ROM_DATA;
            if (commit) csai_q <= next_addr;
        end
    end

    assign ROM_ADDR  = csai_q;
    assign MIR       = mir_q;
    assign DP_COMMIT = commit;
    assign MEM_REQ   = mem_req;

endmodule
